pdua_alu_mc: RTL

PDUA_ALU_MC -- requirements
Module: pdua_alu_mc

---
 rtl/pdua_pkg.sv | 30 +++
 rtl/pdua_alu_iter.sv | 107 ++++++++++
 rtl/pdua_alu_mc.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pdua_pkg.sv
// Shared definitions for the PDUA multi-cycle ALU: operation codes and FSM states.
// Optional multiplier support is selected by the PDUA_ALU_MUL_EN macro.
package pdua_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_NOT   = 4'd5;
   localparam logic [3:0] OP_PASSB = 4'd6;
   localparam logic [3:0] OP_PASSA = 4'd7;
   localparam logic [3:0] OP_SHL   = 4'd8;
   localparam logic [3:0] OP_SHR   = 4'd9;
   localparam logic [3:0] OP_SAR   = 4'd10;
   localparam logic [3:0] OP_ROL   = 4'd11;
   localparam logic [3:0] OP_MUL   = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // True for the four one-bit-per-cycle shift/rotate operations.
   function automatic logic is_shift(input logic [3:0] op);
      return (op >= OP_SHL) && (op <= OP_ROL);
   endfunction

endpackage

// File: rtl/pdua_alu_iter.sv
// Iterative datapath: one shift step or one shift-add multiply step per cycle.
// The multiply path (and its b / hi ports) exists only with PDUA_ALU_MUL_EN.
module pdua_alu_iter
   import pdua_pkg::*;
#(
   parameter int MAX_WIDTH   = 8,
   parameter int SHAMT_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   step,
   input  logic [3:0]             op,
   input  logic [MAX_WIDTH-1:0]   a,
`ifdef PDUA_ALU_MUL_EN
   input  logic [MAX_WIDTH-1:0]   b,
   output logic [MAX_WIDTH-1:0]   hi_next,
`endif
   input  logic [SHAMT_WIDTH-1:0] shamt,
   output logic [MAX_WIDTH-1:0]   lo_next,
   output logic                   c_next,
   output logic                   last
);

   // Counter must hold either the largest shift count or MAX_WIDTH multiply steps.
   localparam int MW = $clog2(MAX_WIDTH + 1);
   localparam int CW = (MW > SHAMT_WIDTH) ? MW : SHAMT_WIDTH;

   logic [3:0]           op_reg;
   logic [MAX_WIDTH-1:0] lo_reg;
   logic [CW-1:0]        cnt_reg;
`ifdef PDUA_ALU_MUL_EN
   logic [MAX_WIDTH-1:0] hi_reg;
   logic [MAX_WIDTH-1:0] mcand_reg;
   logic [MAX_WIDTH:0]   sum;
`endif

   // Load operands on accept, then advance one step per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_reg    <= OP_ADD;
         lo_reg    <= '0;
         cnt_reg   <= '0;
`ifdef PDUA_ALU_MUL_EN
         hi_reg    <= '0;
         mcand_reg <= '0;
`endif
      end else if (load) begin
         op_reg  <= op;
         lo_reg  <= a;
         cnt_reg <= CW'(shamt);
`ifdef PDUA_ALU_MUL_EN
         hi_reg    <= '0;
         mcand_reg <= a;
         if (op == OP_MUL) begin
            lo_reg  <= b;
            cnt_reg <= CW'(MAX_WIDTH);
         end
`endif
      end else if (step) begin
         lo_reg  <= lo_next;
         cnt_reg <= cnt_reg - CW'(1);
`ifdef PDUA_ALU_MUL_EN
         hi_reg  <= hi_next;
`endif
      end
   end

   // Value after the current step; c_next is the bit leaving this step (or hi!=0 for MUL).
   always_comb begin
      lo_next = lo_reg;
      c_next  = 1'b0;
`ifdef PDUA_ALU_MUL_EN
      hi_next = hi_reg;
      sum     = '0;
`endif
      case (op_reg)
         OP_SHL: begin
            lo_next = {lo_reg[MAX_WIDTH-2:0], 1'b0};
            c_next  = lo_reg[MAX_WIDTH-1];
         end
         OP_SHR: begin
            lo_next = {1'b0, lo_reg[MAX_WIDTH-1:1]};
            c_next  = lo_reg[0];
         end
         OP_SAR: begin
            lo_next = {lo_reg[MAX_WIDTH-1], lo_reg[MAX_WIDTH-1:1]};
            c_next  = lo_reg[0];
         end
         OP_ROL: begin
            lo_next = {lo_reg[MAX_WIDTH-2:0], lo_reg[MAX_WIDTH-1]};
            c_next  = lo_reg[MAX_WIDTH-1];
         end
`ifdef PDUA_ALU_MUL_EN
         OP_MUL: begin
            sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : {(MAX_WIDTH+1){1'b0}});
            {hi_next, lo_next} = {sum, lo_reg[MAX_WIDTH-1:1]};
            c_next = |hi_next;
         end
`endif
         default: ;
      endcase
   end

   assign last = (cnt_reg == CW'(1));

endmodule

// File: rtl/pdua_alu_mc.sv
// PDUA multi-cycle ALU: decode, IDLE/RUN/DONE control, result and flag registers.
// Define PDUA_ALU_MUL_EN to include the shift-add unsigned multiplier (selop 12).
module pdua_alu_mc
   import pdua_pkg::*;
#(
   parameter int MAX_WIDTH   = 8,
   parameter int SHAMT_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [3:0]             selop,
   input  logic [SHAMT_WIDTH-1:0] shamt,
   input  logic                   enaf,
   input  logic [MAX_WIDTH-1:0]   a,
   input  logic [MAX_WIDTH-1:0]   b,
   output logic                   busy,
   output logic                   done,
   output logic [MAX_WIDTH-1:0]   result,
   output logic [MAX_WIDTH-1:0]   result_hi,
   output logic                   C,
   output logic                   N,
   output logic                   P,
   output logic                   Z
);

   state_t state_reg, state_next;

   logic                 single, accept, load_iter, step_iter, finish_iter;
   logic [MAX_WIDTH:0]   ext;
   logic [MAX_WIDTH-1:0] s_res, it_lo, fin_res;
   logic                 s_c, it_c, it_last, fin_c, fin_en, upd;
   logic                 enaf_reg;
   logic [MAX_WIDTH-1:0] result_reg;
   logic                 c_reg, n_reg, p_reg, z_reg;
`ifdef PDUA_ALU_MUL_EN
   logic [MAX_WIDTH-1:0] it_hi, fin_hi, result_hi_reg;
`endif

   // Ops that finish in one cycle: everything except non-zero shifts (and MUL when built in).
   always_comb begin
      single = 1'b1;
      if (is_shift(selop)) single = (shamt == '0);
`ifdef PDUA_ALU_MUL_EN
      if (selop == OP_MUL) single = 1'b0;
`endif
   end

   // Single-cycle result and carry straight from the start-time operands.
   always_comb begin
      ext   = '0;
      s_res = a;
      s_c   = 1'b0;
      case (selop)
         OP_ADD: begin
            ext   = {1'b0, a} + {1'b0, b};
            s_res = ext[MAX_WIDTH-1:0];
            s_c   = ext[MAX_WIDTH];
         end
         OP_SUB: begin
            ext   = {1'b0, a} - {1'b0, b};
            s_res = ext[MAX_WIDTH-1:0];
            s_c   = ext[MAX_WIDTH];
         end
         OP_AND:   s_res = a & b;
         OP_OR:    s_res = a | b;
         OP_XOR:   s_res = a ^ b;
         OP_NOT:   s_res = ~a;
         OP_PASSB: s_res = b;
         default:  s_res = a;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // Next state and datapath strobes; start is only looked at outside RUN.
   always_comb begin
      state_next  = state_reg;
      accept      = 1'b0;
      load_iter   = 1'b0;
      step_iter   = 1'b0;
      finish_iter = 1'b0;
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            state_next = ST_IDLE;
            if (start) begin
               accept = 1'b1;
               if (single) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_RUN;
                  load_iter  = 1'b1;
               end
            end
         end
         ST_RUN: begin
            step_iter = 1'b1;
            if (it_last) begin
               finish_iter = 1'b1;
               state_next  = ST_DONE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   pdua_alu_iter #(
      .MAX_WIDTH  (MAX_WIDTH),
      .SHAMT_WIDTH(SHAMT_WIDTH)
   ) u_iter (
      .clk    (clk),
      .rst    (rst),
      .load   (load_iter),
      .step   (step_iter),
      .op     (selop),
      .a      (a),
`ifdef PDUA_ALU_MUL_EN
      .b      (b),
      .hi_next(it_hi),
`endif
      .shamt  (shamt),
      .lo_next(it_lo),
      .c_next (it_c),
      .last   (it_last)
   );

   // Select what gets written at the edge entering DONE.
   always_comb begin
      upd     = (accept && single) || finish_iter;
      fin_res = (accept && single) ? s_res : it_lo;
      fin_c   = (accept && single) ? s_c   : it_c;
      fin_en  = (accept && single) ? enaf  : enaf_reg;
`ifdef PDUA_ALU_MUL_EN
      fin_hi  = (accept && single) ? '0    : it_hi;
`endif
   end

   // Result and flag registers; flags change only on completion with enaf set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enaf_reg   <= 1'b0;
         result_reg <= '0;
         c_reg      <= 1'b0;
         n_reg      <= 1'b0;
         p_reg      <= 1'b0;
         z_reg      <= 1'b0;
`ifdef PDUA_ALU_MUL_EN
         result_hi_reg <= '0;
`endif
      end else begin
         if (load_iter) enaf_reg <= enaf;
         if (upd) begin
            result_reg <= fin_res;
`ifdef PDUA_ALU_MUL_EN
            result_hi_reg <= fin_hi;
`endif
            if (fin_en) begin
               c_reg <= fin_c;
               n_reg <= fin_res[MAX_WIDTH-1];
               z_reg <= (fin_res == '0);
               p_reg <= !fin_res[MAX_WIDTH-1] && (fin_res != '0);
            end
         end
      end
   end

   assign busy   = (state_reg == ST_RUN);
   assign done   = (state_reg == ST_DONE);
   assign result = result_reg;
`ifdef PDUA_ALU_MUL_EN
   assign result_hi = result_hi_reg;
`else
   assign result_hi = '0;
`endif
   assign C = c_reg;
   assign N = n_reg;
   assign P = p_reg;
   assign Z = z_reg;

endmodule
